// File: rtl/hack_serial_pkg.sv
// Shared constants for both ends of the Hack bit-serial link.
// The serializer imports the same values, so both ends agree on word width and bit order.
package hack_serial_pkg;

  localparam int WORD_W            = 16;
  localparam int CNT_W             = $clog2(WORD_W);
  localparam bit LSB_FIRST_DEFAULT = 1'b1;

  // The output buffer is either empty or holding an undelivered word.
  // The assembly register keeps filling in both states.
  typedef enum logic [0:0] {
    EMPTY_FILL = 1'b0,
    FULL_FILL  = 1'b1
  } fill_state_t;

  // Returns the word slot for the bit at serial position pos.
  function automatic int slotIndex(input int pos, input int width, input bit lsbFirst);
    return lsbFirst ? pos : (width - 1 - pos);
  endfunction

endpackage

// File: rtl/dmux_onehot.sv
// WIDTH-way demultiplexer that turns a slot index and a strobe into one-hot write enables.
// It is the counterpart of the select mux in the serializer.
module dmux_onehot
  import hack_serial_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int IDX_W = CNT_W
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_onehot
);

  // Raise exactly the one enable that i_idx selects, and only while i_en is high.
  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < WIDTH; k++) begin
      o_onehot[k] = i_en && (i_idx == IDX_W'(k));
    end
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// Receives the bit-serial Hack link and assembles one WIDTH-bit word per frame.
// Each accepted bit goes into its own slot of an assembly register.
// A finished word is handed out through a single-entry valid/ready buffer.
module serial_word_deserializer
  import hack_serial_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter bit LSB_FIRST = LSB_FIRST_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_start,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sync_err
);

  localparam int               IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(WIDTH - 1);

  fill_state_t      r_state;
  fill_state_t      w_stateNext;
  logic [IDX_W-1:0] r_count;
  logic [WIDTH-1:0] r_asm;
  logic [WIDTH-1:0] r_outWord;
  logic             r_syncErr;

  logic             w_atLast;
  logic             w_accept;
  logic             w_restart;
  logic             w_complete;
  logic [IDX_W-1:0] w_pos;
  logic [IDX_W-1:0] w_slotIdx;
  logic [WIDTH-1:0] w_writeEn;
  logic [WIDTH-1:0] w_asmBase;
  logic [WIDTH-1:0] w_asmMerged;

  // Only the final bit of a word must wait for the output buffer.
  // Every earlier bit lands in the assembly register, so it can always be taken.
  assign w_atLast   = (r_count == LAST_POS);
  assign in_ready   = !(w_atLast && out_valid && !out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_restart  = w_accept && in_start;
  assign w_complete = w_accept && !in_start && w_atLast;

  // A start bit always goes to the first slot, whatever the current count is.
  assign w_pos     = in_start ? '0 : r_count;
  assign w_slotIdx = IDX_W'(slotIndex(int'(w_pos), WIDTH, LSB_FIRST));

  dmux_onehot #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_dmux (
    .i_idx    (w_slotIdx),
    .i_en     (w_accept),
    .o_onehot (w_writeEn)
  );

  // A restart clears any partial word, so stale bits cannot leak into the new frame.
  assign w_asmBase   = in_start ? '0 : r_asm;
  assign w_asmMerged = (w_asmBase & ~w_writeEn) | (w_writeEn & {WIDTH{in_bit}});

  // Track how many bits are assembled, and restart or empty the register at word boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_asm   <= '0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_count <= '0;
        r_asm   <= '0;
      end else if (in_start) begin
        r_count <= IDX_W'(1);
        r_asm   <= w_asmMerged;
      end else begin
        r_count <= r_count + IDX_W'(1);
        r_asm   <= w_asmMerged;
      end
    end
  end

  // Pulse for one cycle when a start bit cuts off a partially received word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_syncErr <= 1'b0;
    end else begin
      r_syncErr <= w_restart && (r_count != '0);
    end
  end

  // Load the finished word, including the final bit, into the output buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outWord <= '0;
    end else if (w_complete) begin
      r_outWord <= w_asmMerged;
    end
  end

  // Register the output buffer occupancy state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY_FILL;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Fill the buffer on completion; drain it on a handshake unless a new word arrives in the same cycle.
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      EMPTY_FILL: if (w_complete) w_stateNext = FULL_FILL;
      FULL_FILL:  if (!w_complete && out_ready) w_stateNext = EMPTY_FILL;
      default:    w_stateNext = EMPTY_FILL;
    endcase
  end

  // Drive the outputs straight from the registered state.
  always_comb begin
    out_valid = (r_state == FULL_FILL);
    out_word  = r_outWord;
    sync_err  = r_syncErr;
  end

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer.
// It uses an LSB-first 16-bit instance, an MSB-first 16-bit instance and a 2-bit instance.
module tb_serial_word_deserializer;

  logic        clk;
  logic        reset;

  logic        aBit, aValid, aStart, aReady, aOutValid, aOutReady, aSyncErr;
  logic [15:0] aWord;
  logic        bBit, bValid, bStart, bReady, bOutValid, bOutReady, bSyncErr;
  logic [15:0] bWord;
  logic        cBit, cValid, cStart, cReady, cOutValid, cOutReady, cSyncErr;
  logic [1:0]  cWord;

  int errors = 0;
  int checks = 0;

  logic [15:0] seq [3] = '{16'h0001, 16'h8000, 16'hFFFF};
  logic [15:0] w;
  int          syncCount;
  int          earlyValid;
  int          readyDrops;

  serial_word_deserializer #(.WIDTH(16), .LSB_FIRST(1'b1)) dutA (
    .clk(clk), .reset(reset), .in_bit(aBit), .in_valid(aValid), .in_start(aStart),
    .in_ready(aReady), .out_word(aWord), .out_valid(aOutValid), .out_ready(aOutReady),
    .sync_err(aSyncErr)
  );

  serial_word_deserializer #(.WIDTH(16), .LSB_FIRST(1'b0)) dutB (
    .clk(clk), .reset(reset), .in_bit(bBit), .in_valid(bValid), .in_start(bStart),
    .in_ready(bReady), .out_word(bWord), .out_valid(bOutValid), .out_ready(bOutReady),
    .sync_err(bSyncErr)
  );

  serial_word_deserializer #(.WIDTH(2), .LSB_FIRST(1'b1)) dutC (
    .clk(clk), .reset(reset), .in_bit(cBit), .in_valid(cValid), .in_start(cStart),
    .in_ready(cReady), .out_word(cWord), .out_valid(cOutValid), .out_ready(cOutReady),
    .sync_err(cSyncErr)
  );

  // Free-running clock with rising edges at 5, 15, 25 and so on.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one bit to instance A, then move to just after the next rising edge.
  task automatic applyStimulus(input logic bitVal, input logic startVal);
    aBit   = bitVal;
    aValid = 1'b1;
    aStart = startVal;
    @(posedge clk);
    #1;
  endtask

  initial begin
    aBit = 0; aValid = 0; aStart = 0; aOutReady = 1;
    bBit = 0; bValid = 0; bStart = 0; bOutReady = 1;
    cBit = 0; cValid = 0; cStart = 0; cOutReady = 1;
    reset = 0;
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    $display("[TB] reset state");
    checkOutput("rstOutValid", 32'(aOutValid), 32'h0);
    checkOutput("rstOutWord", 32'(aWord), 32'h0);
    checkOutput("rstSyncErr", 32'(aSyncErr), 32'h0);
    checkOutput("rstInReady", 32'(aReady), 32'h1);
    checkOutput("rstInReadyB", 32'(bReady), 32'h1);

    $display("[TB] 0xA5C3 LSB-first");
    w = 16'hA5C3;
    syncCount = 0;
    earlyValid = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(w[i], i == 0);
      if (aSyncErr) syncCount++;
      if (i < 15 && aOutValid) earlyValid++;
    end
    checkOutput("a5c3Valid", 32'(aOutValid), 32'h1);
    checkOutput("a5c3Word", 32'(aWord), 32'hA5C3);
    aValid = 0;
    @(posedge clk); #1;
    if (aSyncErr) syncCount++;
    checkOutput("a5c3OneCycle", 32'(aOutValid), 32'h0);
    checkOutput("a5c3NoSync", 32'(syncCount), 32'h0);
    checkOutput("a5c3NoEarly", 32'(earlyValid), 32'h0);

    $display("[TB] 0x1234 MSB-first");
    w = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      bBit = w[15 - i]; bValid = 1'b1; bStart = (i == 0);
      @(posedge clk); #1;
    end
    bValid = 0;
    checkOutput("msbValid", 32'(bOutValid), 32'h1);
    checkOutput("msbWord", 32'(bWord), 32'h1234);
    checkOutput("msbNoSync", 32'(bSyncErr), 32'h0);

    $display("[TB] back-to-back words");
    readyDrops = 0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        aBit = seq[k][i]; aValid = 1'b1; aStart = (i == 0);
        #1;
        if (!aReady) readyDrops++;
        @(posedge clk); #1;
        if (i == 15) begin
          checkOutput("b2bValid", 32'(aOutValid), 32'h1);
          checkOutput("b2bWord", 32'(aWord), 32'(seq[k]));
        end else if (i == 0 && k > 0) begin
          checkOutput("b2bDrained", 32'(aOutValid), 32'h0);
        end
      end
    end
    aValid = 0;
    checkOutput("b2bReadyHeld", 32'(readyDrops), 32'h0);
    @(posedge clk); #1;
    checkOutput("b2bLastDrained", 32'(aOutValid), 32'h0);

    $display("[TB] backpressure");
    aOutReady = 0;
    w = 16'h00FF;
    for (int i = 0; i < 16; i++) applyStimulus(w[i], i == 0);
    checkOutput("bpPendValid", 32'(aOutValid), 32'h1);
    checkOutput("bpPendWord", 32'(aWord), 32'h00FF);
    w = 16'h5555;
    readyDrops = 0;
    for (int i = 0; i < 15; i++) begin
      aBit = w[i]; aValid = 1'b1; aStart = (i == 0);
      #1;
      if (!aReady) readyDrops++;
      @(posedge clk); #1;
    end
    checkOutput("bpEarlyAccepted", 32'(readyDrops), 32'h0);
    aBit = w[15]; aStart = 1'b0;
    #1;
    checkOutput("bpStall", 32'(aReady), 32'h0);
    @(posedge clk); #1;
    checkOutput("bpHoldValid", 32'(aOutValid), 32'h1);
    checkOutput("bpHoldWord", 32'(aWord), 32'h00FF);
    checkOutput("bpStillStalled", 32'(aReady), 32'h0);
    aOutReady = 1;
    #1;
    checkOutput("bpReadyComb", 32'(aReady), 32'h1);
    @(posedge clk); #1;
    checkOutput("bpReloadValid", 32'(aOutValid), 32'h1);
    checkOutput("bpReloadWord", 32'(aWord), 32'h5555);
    aValid = 0;
    @(posedge clk); #1;
    checkOutput("bpDrained", 32'(aOutValid), 32'h0);

    $display("[TB] mid-word restart");
    syncCount = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (aSyncErr) syncCount++;
    end
    w = 16'h3C3C;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(w[i], i == 0);
      if (aSyncErr) syncCount++;
      if (i == 0) checkOutput("syncPulse", 32'(aSyncErr), 32'h1);
    end
    checkOutput("syncWordValid", 32'(aOutValid), 32'h1);
    checkOutput("syncWord", 32'(aWord), 32'h3C3C);
    aValid = 0;
    @(posedge clk); #1;
    if (aSyncErr) syncCount++;
    checkOutput("syncOnce", 32'(syncCount), 32'h1);

    $display("[TB] WIDTH=2");
    cBit = 1; cValid = 1; cStart = 1;
    @(posedge clk); #1;
    cBit = 0; cStart = 0;
    @(posedge clk); #1;
    checkOutput("w2Valid", 32'(cOutValid), 32'h1);
    checkOutput("w2Word", 32'(cWord), 32'h1);
    cBit = 0; cStart = 0;
    @(posedge clk); #1;
    checkOutput("w2Drained", 32'(cOutValid), 32'h0);
    cBit = 1; cStart = 1;
    #1;
    checkOutput("w2ReadyAtLast", 32'(cReady), 32'h1);
    @(posedge clk); #1;
    checkOutput("w2RestartSync", 32'(cSyncErr), 32'h1);
    checkOutput("w2RestartNoWord", 32'(cOutValid), 32'h0);
    cBit = 1; cStart = 0;
    @(posedge clk); #1;
    cValid = 0;
    checkOutput("w2NextValid", 32'(cOutValid), 32'h1);
    checkOutput("w2NextWord", 32'(cWord), 32'h3);
    checkOutput("w2SyncCleared", 32'(cSyncErr), 32'h0);

    $display("[TB] asynchronous reset");
    aOutReady = 0;
    w = 16'h1111;
    for (int i = 0; i < 16; i++) applyStimulus(w[i], i == 0);
    checkOutput("arPendValid", 32'(aOutValid), 32'h1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, i == 0);
    aValid = 0;
    #2 reset = 1;
    #1;
    checkOutput("arOutValid", 32'(aOutValid), 32'h0);
    checkOutput("arOutWord", 32'(aWord), 32'h0);
    checkOutput("arSyncErr", 32'(aSyncErr), 32'h0);
    #1 reset = 0;
    aOutReady = 1;
    w = 16'hBEEF;
    syncCount = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(w[i], i == 0);
      if (aSyncErr) syncCount++;
    end
    aValid = 0;
    checkOutput("beefValid", 32'(aOutValid), 32'h1);
    checkOutput("beefWord", 32'(aWord), 32'hBEEF);
    checkOutput("beefNoSync", 32'(syncCount), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_deserializer.md
Name: serial_word_deserializer

Overview:
- Receiving end of the bit-serial link driven by the Mux-based word serializer.
- The serializer uses a counter-driven select to pick one bit per cycle out of a 16-bit Hack word. This block does the inverse: it routes each incoming bit into its slot of an assembly register, DMux-style.
- Once a full word is assembled, it is presented on a valid/ready output.
- Sits between the serial link pins (after synchronisation) and the Hack memory-mapped peripheral register.

Parameters:
- WIDTH, 16, word width in bits (≥2).
- LSB_FIRST, 1, 1: first received bit lands in out_word[0]; 0: first bit lands in out_word[WIDTH-1].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_start  input  1  qualifies in_bit as the first bit of a word; sampled only when the bit is accepted.
- in_ready  output  1  block accepts in_bit this cycle.
- out_word  output  WIDTH  assembled word.
- out_valid  output  1  out_word holds an undelivered word.
- out_ready  input  1  consumer takes out_word this cycle.
- sync_err  output  1  one-cycle pulse: in_start arrived mid-word and the partial word was discarded.

Behaviour:
Clock/reset:
- One clock.
- Reset is asynchronous and active-high.
- Reset values: count=0, asm=0, out_word=0, out_valid=0, sync_err=0.
- Reset mid-word discards the partial word. Reset with out_valid=1 drops the pending word.

State:
- count: 0..WIDTH-1, bits held in asm.
- out_valid: output buffer full or empty.
- Effective FSM states:
  - EMPTY_FILL (out_valid=0)
  - FULL_FILL (out_valid=1)

Bit acceptance:
- A bit is accepted when in_valid && in_ready.
- in_ready = !(count==WIDTH-1 && out_valid && !out_ready). It is combinational from out_ready; no other combinational input-to-output paths exist.
- Slot index = count when LSB_FIRST=1, else WIDTH-1-count. Only that asm bit is written (one-hot write enable from a decoder).
- Accepted with in_start=1: bit is written to slot for index 0, and count becomes 1.
  - If the old count was nonzero, other asm bits are cleared and sync_err pulses on the next cycle.
  - If the old count was 0, no error.
- Accepted with in_start=0 at count 0 starts a word normally; framing is optional.

Word completion:
- The accepted bit with count==WIDTH-1 (and in_start=0) completes the word.
- At the next edge: out_word = asm with the final bit merged, out_valid=1, count=0, asm=0.
- Latency: last bit accepted at edge N → out_valid=1 after edge N.

Output handshake:
- out_valid && out_ready at an edge clears out_valid, unless a new word completes at that same edge. In that case out_word reloads and out_valid stays 1.
- out_word is stable while out_valid=1 && !out_ready.
- Full throughput: one word per WIDTH cycles with in_valid and out_ready held high.

Boundary cases:
- Backpressure: if the output is full and not draining, the final bit of the next word is stalled (in_ready=0). Earlier bits of that word are still accepted.
- in_valid=0: no state change except the output handshake.
- in_start on the final bit position restarts the word. No completion occurs; sync_err pulses.
- WIDTH=2: count wraps after 2 bits; all rules above still hold.

Decomposition:
- Shared package (hack_serial_pkg):
  - WORD_W=16
  - CNT_W=$clog2(WIDTH)
  - LSB_FIRST default
  - The same constants are used by the serializer, so both ends agree on bit order.
- Sub-module: dmux_onehot.
  - Combinational WIDTH-way demultiplexer.
  - Turns the slot index plus accept strobe into one-hot bit write enables.
  - The DMux counterpart of the serializer's select mux.

Test Plan:
- Reset, then 16 bits of 0xA5C3 LSB-first with in_valid=1, out_ready=1 → out_valid=1 for exactly one cycle, one cycle after the 16th bit, out_word=0xA5C3, sync_err never asserted.
- LSB_FIRST=0, send bits of 0x1234 MSB-first → out_word=0x1234.
- Back-to-back 0x0001, 0x8000, 0xFFFF, out_ready=1 continuously → in_ready never drops, three words on consecutive 16-cycle boundaries.
- out_ready=0 with 0x00FF pending; stream 0x5555 → 15 bits accepted, in_ready=0 on the 16th, out_word holds 0x00FF.
  - Raise out_ready → 0x00FF delivered, the 16th bit is accepted the same cycle, next cycle out_word=0x5555.
- 7 bits sent, then a bit with in_start=1, then 15 more bits of 0x3C3C → sync_err pulses once, the next word is 0x3C3C (partial discarded).
- Assert reset asynchronously mid-word (count=9) and while out_valid=1 → outputs go to 0 immediately, without waiting for a clock edge. A following full word 0xBEEF is received correctly.
